// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with DONE/withdraw release and a hold-limit timeout.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       valid,
  output logic       timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [2:0] ptr, ptr_n, k, idx, gnt_id_n;
  logic [7:0] hcnt, hcnt_n, gnt_n;
  logic       valid_n, timeout_n, hit, rel;
  always_comb begin
    k = ptr;
    idx = ptr;
    for (int i = 7; i >= 0; i--) begin
      idx = ptr + 3'(i);
      k = req[idx] ? idx : k;
    end
  end
  assign hit = (MAX_HOLD != 0) && (hcnt == 8'(MAX_HOLD));
  assign rel = done || !req[gnt_id] || hit;
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    hcnt_n = hcnt;
    gnt_n = gnt;
    gnt_id_n = gnt_id;
    valid_n = valid;
    timeout_n = 1'b0;
    if (state == IDLE) begin
      if (|req) begin
        state_n = GRANT;
        gnt_n = 8'b1 << k;
        gnt_id_n = k;
        valid_n = 1'b1;
        hcnt_n = 8'd1;
        ptr_n = k + 3'd1;
      end
    end else if (rel) begin
      state_n = IDLE;
      gnt_n = 8'h00;
      gnt_id_n = 3'd0;
      valid_n = 1'b0;
      hcnt_n = 8'd0;
      timeout_n = !done && req[gnt_id] && hit;
    end else begin
      hcnt_n = (hcnt == 8'hFF) ? hcnt : hcnt + 8'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= 3'd0;
      hcnt <= 8'd0;
      gnt <= 8'h00;
      gnt_id <= 3'd0;
      valid <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      hcnt <= hcnt_n;
      gnt <= gnt_n;
      gnt_id <= gnt_id_n;
      valid <= valid_n;
      timeout <= timeout_n;
    end
  end
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed vectors with hand-computed grants for rr_arbiter8 (MAX_HOLD=4).
module tb_rr_arbiter8;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       valid;
  logic       timeout;
  int         n_cmp = 0;
  int         n_err = 0;
  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .valid(valid), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got to/v/id/gnt=%b/%b/%0d/%02h expected %b/%b/%0d/%02h", tag,
               got[12], got[11], got[10:8], got[7:0], exp[12], exp[11], exp[10:8], exp[7:0]);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic st(input string tag, input logic [7:0] egnt, input logic [2:0] eid, input logic eto);
    chk(tag, {timeout, valid, gnt_id, gnt}, {eto, |egnt, eid, egnt});
  endtask
  initial begin
    rst_n = 1'b0;
    req = 8'hFF;
    done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      st("reset", 8'h00, 3'd0, 1'b0);
    end
    rst_n = 1'b1;
    tick();
    st("first_grant", 8'h01, 3'd0, 1'b0);
    for (int j = 1; j <= 8; j++) begin
      done = 1'b1;
      tick();
      st("fair_gap", 8'h00, 3'd0, 1'b0);
      done = 1'b0;
      tick();
      st($sformatf("fair_%0d", j % 8), 8'h01 << (j % 8), 3'(j % 8), 1'b0);
    end
    done = 1'b1;
    tick();
    st("fair_rel", 8'h00, 3'd0, 1'b0);
    done = 1'b0;
    req = 8'h00;
    tick();
    st("idle", 8'h00, 3'd0, 1'b0);
    req = 8'h20;
    tick();
    st("single", 8'h20, 3'd5, 1'b0);
    done = 1'b1;
    tick();
    st("single_rel", 8'h00, 3'd0, 1'b0);
    done = 1'b0;
    tick();
    st("single_regrant", 8'h20, 3'd5, 1'b0);
    done = 1'b1;
    tick();
    st("single_rel2", 8'h00, 3'd0, 1'b0);
    done = 1'b0;
    req = 8'h09;
    tick();
    st("wrap_0", 8'h01, 3'd0, 1'b0);
    done = 1'b1;
    tick();
    st("wrap_gap", 8'h00, 3'd0, 1'b0);
    done = 1'b0;
    tick();
    st("wrap_3", 8'h08, 3'd3, 1'b0);
    done = 1'b1;
    tick();
    st("wrap_rel", 8'h00, 3'd0, 1'b0);
    done = 1'b0;
    req = 8'h04;
    for (int c = 1; c <= 4; c++) begin
      tick();
      st($sformatf("hold_%0d", c), 8'h04, 3'd2, 1'b0);
    end
    tick();
    st("timeout_gap", 8'h00, 3'd0, 1'b1);
    tick();
    st("timeout_regrant", 8'h04, 3'd2, 1'b0);
    tick();
    tick();
    tick();
    st("hold_4_again", 8'h04, 3'd2, 1'b0);
    done = 1'b1;
    tick();
    st("done_beats_limit", 8'h00, 3'd0, 1'b0);
    done = 1'b0;
    tick();
    st("regrant_2", 8'h04, 3'd2, 1'b0);
    req = 8'h00;
    tick();
    st("withdraw", 8'h00, 3'd0, 1'b0);
    tick();
    st("withdraw_idle", 8'h00, 3'd0, 1'b0);
    req = 8'h08;
    tick();
    st("pre_reset_grant", 8'h08, 3'd3, 1'b0);
    rst_n = 1'b0;
    req = 8'hFF;
    tick();
    st("mid_reset", 8'h00, 3'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    st("post_reset_grant", 8'h01, 3'd0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter that shares one datapath resource among 8 requesters. It is the sequential counterpart of the team's 8-to-3 priority encoder. The search starts at a rotating pointer rather than a fixed top bit, so no requester starves. Each grant is held until the owner releases it or a programmable hold limit expires. The block sits between the requesting units and the shared resource and drives the resource's select (GNT_ID) and enable (VALID).

## Interface
- MAX_HOLD, 16: maximum consecutive cycles a single grant may last. Legal range 0..255. 0 disables the limit.
- CLK  in  1  rising-edge clock, the only clock.
- RST_N  in  1  synchronous, active-low reset, sampled on CLK rising edge.
- REQ  in  8  request vector. Bit i = requester i wants the resource. Level-sensitive.
- DONE  in  1  release strobe from the current grant holder. Ignored while VALID=0.
- GNT  out  8  one-hot grant, or 8'h00 when idle. Registered.
- GNT_ID  out  3  binary index of the granted requester. Registered. Reads 3'd0 when VALID=0, never x.
- VALID  out  1  a grant is active. Equals |GNT. Registered.
- TIMEOUT  out  1  one-cycle pulse when a grant is revoked by the MAX_HOLD limit. Registered.

## Operation
- Internal state:
  - FSM with states IDLE and GRANT.
  - 3-bit pointer PTR.
  - 8-bit hold counter HCNT.
- Reset values, applied when RST_N=0 at an edge, regardless of any other input:
  - Outputs: GNT=8'h00, GNT_ID=0, VALID=0, TIMEOUT=0.
  - Internal: state=IDLE, PTR=0, HCNT=0.
- IDLE:
  - If REQ==0, stay in IDLE.
  - Otherwise, search REQ in order PTR, PTR+1, …, 7, 0, …, PTR-1 (mod 8) and pick the first set bit k.
  - At the next edge: GNT=1<<k, GNT_ID=k, VALID=1, HCNT=1, PTR=(k+1) mod 8, state=GRANT.
- GRANT, holder k. Release is evaluated at every edge. Priority order:
  1. DONE=1: release, TIMEOUT=0.
  2. REQ[k]=0 (requester withdrew): release, TIMEOUT=0.
  3. MAX_HOLD≠0 and HCNT==MAX_HOLD: release, TIMEOUT=1 for exactly one cycle.
  4. Otherwise: hold, HCNT=HCNT+1. HCNT never exceeds MAX_HOLD and never wraps. With MAX_HOLD=0 it saturates at 255.
- On release: GNT=0, VALID=0, GNT_ID=0, HCNT=0, state=IDLE.
- Changes to REQ bits other than k during GRANT have no effect until the next IDLE cycle.
- PTR changes only on a new grant. A timed-out requester moves to lowest round-robin priority, like any other holder.
- A requester that keeps REQ high after release competes normally. If it is the only requester, it is re-granted.

## Timing
- Request to grant: REQ sampled at edge t while in IDLE → GNT valid from edge t (visible in the cycle after t). One-cycle latency.
- Release to next grant: there is always exactly one cycle with VALID=0 between consecutive grants, including the same requester re-granted.
  - Back-to-back ownership changes therefore cost 2 cycles.
- The maximum grant length is MAX_HOLD cycles of VALID=1.
- TIMEOUT is high in the gap cycle immediately after the last granted cycle.
- DONE and the hold limit in the same cycle: treated as a DONE release, TIMEOUT stays 0.
- DONE in the very first grant cycle: releases after a 1-cycle grant.
- Reset in mid-grant: at the next edge, GNT drops to 0 and all reset values apply. No TIMEOUT pulse, and the prior PTR is lost.
- All outputs are glitch-free register outputs. There is no combinational path from REQ or DONE to any output.

## Test plan
- Reset: hold RST_N=0 for 3 cycles with REQ=8'hFF → GNT=0, VALID=0, GNT_ID=0, TIMEOUT=0 throughout. Release reset → first grant is GNT=8'h01, GNT_ID=0, one cycle later.
- Single request: REQ=8'h20 sampled at edge t → GNT=8'h20, GNT_ID=5, VALID=1 from edge t. Pulse DONE for one cycle → GNT=0 at the next edge, then GNT=8'h20 again one cycle later if REQ is still high.
- Fairness: REQ=8'hFF held, DONE pulsed in each first grant cycle → GNT_ID sequence 0,1,2,…,7,0. Each grant lasts 1 cycle, followed by a 1-cycle gap.
- Wrap-around: grant requester 5 and release it (PTR=6). Then apply REQ=8'h09 → grant ID 0 first; after its release, grant ID 3.
- Timeout: MAX_HOLD=4, REQ=8'h04 held, DONE=0 → VALID=1 for exactly 4 cycles, then a gap cycle with TIMEOUT=1 and VALID=0, then re-grant to ID 2. Also drive DONE=1 in the 4th grant cycle → no TIMEOUT pulse.
- Withdraw and mid-grant reset: drop REQ[k] while granted → GNT=0 at the next edge, TIMEOUT=0. Separately, assert RST_N=0 during a grant → all outputs 0 at the next edge, and arbitration restarts from ID 0.
